cpu_ma: RTL and testbench

//  Memory-access stage of the 5-stage RISC-V pipeline; consumes the EX pipeline bundle (pc/ir/ma_*/wb_*).

---
 rtl/cpu_ma_pkg.sv | 46 ++++
 rtl/cpu_ma_align.sv | 51 +++++
 rtl/cpu_ma.sv | 159 +++++++++++++++
 tb/tb_cpu_ma.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ma_pkg.sv
// Shared types and constants for the cpu_ma memory-access stage.
// Encodings follow RISC-V funct3 for access sizes; NOP_* describe a pipeline bubble.
package cpu_ma_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MA_NONE  = 2'd0,
        MA_LOAD  = 2'd1,
        MA_STORE = 2'd2
    } ma_mode_t;

    typedef enum logic [2:0] {
        MA_B  = 3'b000,
        MA_H  = 3'b001,
        MA_W  = 3'b010,
        MA_BU = 3'b100,
        MA_HU = 3'b101
    } ma_size_t;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'd0,
        WB_SRC_MEM = 2'd1,
        WB_SRC_PC  = 2'd2,
        WB_SRC_CSR = 2'd3
    } wb_src_t;

    typedef enum logic {
        MA_IDLE = 1'b0,
        MA_WAIT = 1'b1
    } ma_state_t;

    localparam logic [XLEN-1:0] NOP_PC       = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] NOP_IR       = 32'h0000_0013;
    localparam logic            NOP_WB_VALID = 1'b0;

    // True when the access is not naturally aligned for its size.
    function automatic logic is_misaligned(ma_size_t size, logic [1:0] lo);
        case (size)
            MA_H, MA_HU: return lo[0];
            MA_W:        return lo != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cpu_ma_align.sv
// Combinational lane logic: store byte enables / replicated write data and
// load byte/halfword extraction with sign or zero extension.
module cpu_ma_align
    import cpu_ma_pkg::*;
(
    input  ma_size_t    size,
    input  logic [1:0]  lane_addr,
    input  logic        store,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);

    logic [1:0]  lane;
    logic [15:0] shifted;

    always_comb begin
        lane      = 2'b00;
        be        = 4'b1111;
        wdata     = store_data;
        load_data = rdata;

        // Halfwords snap to a[1]; words always use lane 0.
        case (size)
            MA_B, MA_BU: begin
                lane  = lane_addr;
                wdata = {4{store_data[7:0]}};
                if (store) be = 4'b0001 << lane;
            end
            MA_H, MA_HU: begin
                lane  = {lane_addr[1], 1'b0};
                wdata = {2{store_data[15:0]}};
                if (store) be = 4'b0011 << lane;
            end
            default: ;
        endcase

        shifted = 16'(rdata >> {lane, 3'b000});

        case (size)
            MA_B:    load_data = {{24{shifted[7]}}, shifted[7:0]};
            MA_BU:   load_data = {24'b0, shifted[7:0]};
            MA_H:    load_data = {{16{shifted[15]}}, shifted[15:0]};
            MA_HU:   load_data = {16'b0, shifted[15:0]};
            default: load_data = rdata;
        endcase
    end

endmodule

// File: rtl/cpu_ma.sv
// Memory-access pipeline stage: data-memory req/ack, stall, forwarding and WB register.
// Optional macro CPU_MA_MISALIGN_TRAP_EN: misaligned H/HU/W faults instead of accessing.
module cpu_ma
    import cpu_ma_pkg::*;
#(
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    input  logic [31:0] ma_addr_i,
    input  ma_mode_t    ma_mode_i,
    input  ma_size_t    ma_size_i,
    input  logic [31:0] ma_data_i,
    input  wb_src_t     wb_src_i,
    input  logic [31:0] wb_data_i,
    input  logic        wb_valid_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_async_o,
    output logic [4:0]  wb_addr_async_o,
    output logic [31:0] wb_data_async_o,
    output logic        wb_ready_async_o,
    output logic        wb_valid_async_o,
    output logic        empty_async_o,
    output logic        fault_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [31:0] wb_data_o,
    output logic        wb_valid_o
);

    localparam int unsigned CNT_W = (DMEM_TIMEOUT < 2) ? 1 : $clog2(DMEM_TIMEOUT + 1);

    ma_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             req, timeout, mis_fault, misalign, ack, bubble;
    logic [31:0]      load_data;

`ifdef CPU_MA_MISALIGN_TRAP_EN
    assign misalign = is_misaligned(ma_size_i, ma_addr_i[1:0]);
`else
    assign misalign = 1'b0;
`endif

    cpu_ma_align u_align (
        .size       (ma_size_i),
        .lane_addr  (ma_addr_i[1:0]),
        .store      (ma_mode_i == MA_STORE),
        .store_data (ma_data_i),
        .rdata      (dmem_rdata_i),
        .be         (dmem_be_o),
        .wdata      (dmem_wdata_o),
        .load_data  (load_data)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= MA_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    // Request/next-state; the WAIT counter starts at 1 so req lasts DMEM_TIMEOUT cycles.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        req       = 1'b0;
        timeout   = 1'b0;
        mis_fault = 1'b0;
        unique case (state)
            MA_IDLE: begin
                if (ma_mode_i != MA_NONE) begin
                    if (misalign) begin
                        mis_fault = 1'b1;
                    end else begin
                        req = 1'b1;
                        if (!dmem_ack_i) begin
                            state_n = MA_WAIT;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
            end
            MA_WAIT: begin
                if (DMEM_TIMEOUT != 0 && cnt == CNT_W'(DMEM_TIMEOUT)) begin
                    timeout = 1'b1;
                    state_n = MA_IDLE;
                    cnt_n   = '0;
                end else begin
                    req = 1'b1;
                    if (dmem_ack_i) begin
                        state_n = MA_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = MA_IDLE;
                cnt_n   = '0;
            end
        endcase
        // Reset must drop the request without waiting for a clock edge.
        if (!reset_n_i) begin
            req       = 1'b0;
            timeout   = 1'b0;
            mis_fault = 1'b0;
        end
    end

    assign ack    = req && dmem_ack_i;
    assign bubble = (req && !dmem_ack_i) || timeout;

    assign dmem_req_o       = req;
    assign dmem_we_o        = req && (ma_mode_i == MA_STORE);
    assign dmem_addr_o      = {ma_addr_i[31:2], 2'b00};
    assign stall_async_o    = req && !dmem_ack_i;
    assign wb_addr_async_o  = ir_i[11:7];
    assign wb_data_async_o  = (wb_src_i == WB_SRC_MEM) ? load_data : wb_data_i;
    assign wb_ready_async_o = !((wb_src_i == WB_SRC_MEM) && !ack);
    assign wb_valid_async_o = wb_valid_i;
    assign empty_async_o    = (pc_i == NOP_PC);

    // WB bundle register; stalled or timed-out instructions leave a bubble.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            pc_o       <= NOP_PC;
            ir_o       <= NOP_IR;
            wb_data_o  <= '0;
            wb_valid_o <= NOP_WB_VALID;
            fault_o    <= 1'b0;
        end else begin
            fault_o <= timeout || mis_fault;
            if (bubble) begin
                pc_o       <= NOP_PC;
                ir_o       <= NOP_IR;
                wb_data_o  <= '0;
                wb_valid_o <= NOP_WB_VALID;
            end else begin
                pc_o       <= pc_i;
                ir_o       <= ir_i;
                wb_data_o  <= wb_data_async_o;
                wb_valid_o <= wb_valid_i && !mis_fault;
            end
        end
    end

endmodule

// File: tb/tb_cpu_ma.sv
// Self-checking bench for cpu_ma: directed vector table, multi-cycle sequences
// and randomized accesses against a byte-lane arithmetic reference model.
module tb_cpu_ma;
    import cpu_ma_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc = 32'h0, ir = 32'h0, addr = 32'h0, sdata = 32'h0, wbd = 32'h0;
    ma_mode_t    mode = MA_NONE;
    ma_size_t    size = MA_W;
    wb_src_t     src = WB_SRC_ALU;
    logic        wbv = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] rdata = 32'h0;

    logic        req, we, stall, wbr, wbva, empty, fault, wbv_o;
    logic [31:0] daddr, wdata, wbda, pc_o, ir_o, wbd_o;
    logic [3:0]  be;
    logic [4:0]  wba;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_ma #(.DMEM_TIMEOUT(TO)) dut (
        .clk_i            (clk),
        .reset_n_i        (rst_n),
        .pc_i             (pc),
        .ir_i             (ir),
        .ma_addr_i        (addr),
        .ma_mode_i        (mode),
        .ma_size_i        (size),
        .ma_data_i        (sdata),
        .wb_src_i         (src),
        .wb_data_i        (wbd),
        .wb_valid_i       (wbv),
        .dmem_req_o       (req),
        .dmem_we_o        (we),
        .dmem_addr_o      (daddr),
        .dmem_be_o        (be),
        .dmem_wdata_o     (wdata),
        .dmem_ack_i       (ack),
        .dmem_rdata_i     (rdata),
        .stall_async_o    (stall),
        .wb_addr_async_o  (wba),
        .wb_data_async_o  (wbda),
        .wb_ready_async_o (wbr),
        .wb_valid_async_o (wbva),
        .empty_async_o    (empty),
        .fault_o          (fault),
        .pc_o             (pc_o),
        .ir_o             (ir_o),
        .wb_data_o        (wbd_o),
        .wb_valid_o       (wbv_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: byte lanes computed arithmetically from size and address.
    function automatic int unsigned nbytes(ma_size_t s);
        case (s)
            MA_B, MA_BU: return 1;
            MA_H, MA_HU: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic int unsigned lane_of(ma_size_t s, logic [31:0] a);
        int unsigned nb = nbytes(s);
        return ((32'(a) % 4) / nb) * nb;
    endfunction

    function automatic logic [3:0] model_be(ma_size_t s, logic [31:0] a);
        logic [3:0]  m  = 4'b0000;
        int unsigned ln = lane_of(s, a);
        int unsigned nb = nbytes(s);
        for (int unsigned i = 0; i < 4; i++)
            if (i >= ln && i < ln + nb) m[i[1:0]] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] model_wdata(ma_size_t s, logic [31:0] d);
        int unsigned nb = nbytes(s);
        if (nb == 1) return 32'(d[7:0]) * 32'h0101_0101;
        if (nb == 2) return 32'(d[15:0]) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(ma_size_t s, logic [31:0] a, logic [31:0] r);
        int unsigned       nb   = nbytes(s);
        int unsigned       ln   = lane_of(s, a);
        longint unsigned   span = 64'd1 << (8 * nb);
        longint unsigned   v    = ({32'b0, r} >> (8 * ln)) % span;
        if ((s == MA_B || s == MA_H) && v >= span / 2) v = v + (64'd1 << 32) - span;
        return v[31:0];
    endfunction

    function automatic ma_size_t pick_size(int unsigned k);
        case (k)
            0:       return MA_B;
            1:       return MA_H;
            2:       return MA_W;
            3:       return MA_BU;
            default: return MA_HU;
        endcase
    endfunction

    typedef struct {
        ma_mode_t    mode;
        ma_size_t    size;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        wb_src_t     src;
        logic [31:0] wbd;
        logic [3:0]  be_exp;
        logic [31:0] wdata_exp;
        logic [31:0] wb_exp;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{MA_LOAD,  MA_W,  32'h100, 32'h0,        32'hDEADBEEF, WB_SRC_MEM, 32'h0,  4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{MA_LOAD,  MA_HU, 32'h102, 32'h0,        32'h8001_1234, WB_SRC_MEM, 32'h0, 4'b1111, 32'h0,        32'h0000_8001};
        vecs[2]  = '{MA_LOAD,  MA_H,  32'h102, 32'h0,        32'h8001_1234, WB_SRC_MEM, 32'h0, 4'b1111, 32'h0,        32'hFFFF_8001};
        vecs[3]  = '{MA_LOAD,  MA_B,  32'h103, 32'h0,        32'h8012_3456, WB_SRC_MEM, 32'h0, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vecs[4]  = '{MA_LOAD,  MA_BU, 32'h101, 32'h0,        32'h0000_FF00, WB_SRC_MEM, 32'h0, 4'b1111, 32'h0,        32'h0000_00FF};
        vecs[5]  = '{MA_LOAD,  MA_H,  32'h100, 32'h0,        32'h1234_7FFE, WB_SRC_MEM, 32'h0, 4'b1111, 32'h0,        32'h0000_7FFE};
        vecs[6]  = '{MA_STORE, MA_B,  32'h201, 32'h0000_00AB, 32'h0, WB_SRC_ALU, 32'h1111_0006, 4'b0010, 32'hABAB_ABAB, 32'h1111_0006};
        vecs[7]  = '{MA_STORE, MA_H,  32'h202, 32'h0000_1234, 32'h0, WB_SRC_ALU, 32'h1111_0007, 4'b1100, 32'h1234_1234, 32'h1111_0007};
        vecs[8]  = '{MA_STORE, MA_W,  32'h300, 32'hCAFE_F00D, 32'h0, WB_SRC_ALU, 32'h1111_0008, 4'b1111, 32'hCAFE_F00D, 32'h1111_0008};
        vecs[9]  = '{MA_STORE, MA_B,  32'h003, 32'hFFFF_FF5A, 32'h0, WB_SRC_ALU, 32'h1111_0009, 4'b1000, 32'h5A5A_5A5A, 32'h1111_0009};
        vecs[10] = '{MA_NONE,  MA_W,  32'h000, 32'h0,        32'h0, WB_SRC_ALU, 32'h0000_0077, 4'b1111, 32'h0,        32'h0000_0077};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc_o, NOP_PC);
        chk("rst_ir", ir_o, NOP_IR);
        chk("rst_wbd", wbd_o, 32'h0);
        chk("rst_wbv", 32'(wbv_o), 32'(NOP_WB_VALID));
        chk("rst_fault", 32'(fault), 32'h0);
        chk("rst_req", 32'(req), 32'h0);
        rst_n = 1'b1;
        tick();

        // Directed single-cycle accesses
        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].mode; size = vecs[i].size; addr = vecs[i].addr;
            sdata = vecs[i].sdata; rdata = vecs[i].rdata; src = vecs[i].src; wbd = vecs[i].wbd;
            pc = 32'h1000 + 32'(i) * 4; ir = 32'h0000_0A83; wbv = 1'b1;
            ack = (vecs[i].mode != MA_NONE);
            #1;
            chk($sformatf("v%0d_req", i), 32'(req), 32'(vecs[i].mode != MA_NONE));
            if (vecs[i].mode != MA_NONE) begin
                chk($sformatf("v%0d_be", i), 32'(be), 32'(vecs[i].be_exp));
                chk($sformatf("v%0d_we", i), 32'(we), 32'(vecs[i].mode == MA_STORE));
                chk($sformatf("v%0d_addr", i), daddr, vecs[i].addr & 32'hFFFF_FFFC);
            end
            if (vecs[i].mode == MA_STORE) chk($sformatf("v%0d_wdata", i), wdata, vecs[i].wdata_exp);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'h0);
            chk($sformatf("v%0d_wbda", i), wbda, vecs[i].wb_exp);
            tick();
            chk($sformatf("v%0d_wbd_o", i), wbd_o, vecs[i].wb_exp);
            chk($sformatf("v%0d_wbv_o", i), 32'(wbv_o), 32'h1);
            chk($sformatf("v%0d_pc_o", i), pc_o, 32'h1000 + 32'(i) * 4);
            ack = 1'b0;
        end
        mode = MA_NONE;
        chk("wb_addr", 32'(wba), 32'h15);

        // Empty detection and stray ack in IDLE
        pc = NOP_PC; ack = 1'b1; wbv = 1'b1; wbd = 32'h55; src = WB_SRC_ALU;
        #1;
        chk("empty", 32'(empty), 32'h1);
        chk("stray_req", 32'(req), 32'h0);
        chk("stray_stall", 32'(stall), 32'h0);
        tick();
        chk("stray_wbd", wbd_o, 32'h55);
        ack = 1'b0; pc = 32'h2000;

        // LB with ack after 3 cycles
        mode = MA_LOAD; size = MA_B; addr = 32'h103; src = WB_SRC_MEM; rdata = 32'h0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("lb_stall%0d", k), 32'(stall), 32'h1);
            chk($sformatf("lb_ready%0d", k), 32'(wbr), 32'h0);
            tick();
            chk($sformatf("lb_bubble%0d", k), 32'(wbv_o), 32'h0);
            chk($sformatf("lb_bubpc%0d", k), pc_o, NOP_PC);
        end
        ack = 1'b1; rdata = 32'h80AB_CDEF;
        #1;
        chk("lb_stall_done", 32'(stall), 32'h0);
        chk("lb_ready_done", 32'(wbr), 32'h1);
        tick();
        chk("lb_wbd", wbd_o, 32'hFFFF_FF80);
        chk("lb_wbv", 32'(wbv_o), 32'h1);
        ack = 1'b0; mode = MA_NONE;
        tick();

        // Timeout: request for TO cycles then fault
        mode = MA_LOAD; size = MA_W; addr = 32'h400;
        for (int k = 0; k < int'(TO); k++) begin
            #1;
            chk($sformatf("to_req%0d", k), 32'(req), 32'h1);
            tick();
        end
        #1;
        chk("to_req_drop", 32'(req), 32'h0);
        chk("to_stall", 32'(stall), 32'h0);
        tick();
        mode = MA_NONE;
        chk("to_fault", 32'(fault), 32'h1);
        chk("to_wbv", 32'(wbv_o), 32'h0);
        tick();
        chk("to_fault_pulse", 32'(fault), 32'h0);

        // Reset mid-access
        mode = MA_LOAD; size = MA_W; addr = 32'h500;
        tick();
        chk("mr_req_wait", 32'(req), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mr_req", 32'(req), 32'h0);
        chk("mr_stall", 32'(stall), 32'h0);
        chk("mr_pc", pc_o, NOP_PC);
        chk("mr_ir", ir_o, NOP_IR);
        mode = MA_NONE;
        tick();
        rst_n = 1'b1;
        tick();

        // Misaligned access
        mode = MA_LOAD; size = MA_W; addr = 32'h101; src = WB_SRC_MEM; wbv = 1'b1; rdata = 32'h1122_3344;
`ifdef CPU_MA_MISALIGN_TRAP_EN
        ack = 1'b0;
        #1;
        chk("mis_req", 32'(req), 32'h0);
        chk("mis_stall", 32'(stall), 32'h0);
        tick();
        mode = MA_NONE;
        chk("mis_fault", 32'(fault), 32'h1);
        chk("mis_wbv", 32'(wbv_o), 32'h0);
`else
        ack = 1'b1;
        #1;
        chk("mis_req", 32'(req), 32'h1);
        tick();
        chk("mis_w_lane0", wbd_o, 32'h1122_3344);
        chk("mis_nofault", 32'(fault), 32'h0);
        size = MA_H; addr = 32'h103; rdata = 32'hABCD_1234;
        tick();
        chk("mis_h_a1", wbd_o, 32'hFFFF_ABCD);
        mode = MA_NONE;
`endif
        ack = 1'b0;
        tick();

        // Randomized accesses against the reference model
        for (int it = 0; it < 300; it++) begin
            int unsigned r   = $urandom_range(0, 9);
            int unsigned dly;
            logic [31:0] exp_wb;
            mode = (r < 4) ? MA_LOAD : (r < 8) ? MA_STORE : MA_NONE;
            size = (mode == MA_STORE) ? pick_size($urandom_range(0, 2)) : pick_size($urandom_range(0, 4));
            addr = $urandom;
`ifdef CPU_MA_MISALIGN_TRAP_EN
            addr = addr & ~32'(nbytes(size) - 1);
`endif
            sdata = $urandom; rdata = $urandom; wbd = $urandom; wbv = 1'($urandom);
            pc = $urandom & 32'hFFFF_FFFC; ir = $urandom;
            src = (mode == MA_LOAD) ? WB_SRC_MEM : WB_SRC_ALU;
            dly = (mode == MA_NONE) ? 0 : $urandom_range(0, 2);
            exp_wb = (mode == MA_LOAD) ? model_load(size, addr, rdata) : wbd;
            ack = 1'b0;
            for (int unsigned k = 0; k < dly; k++) begin
                #1;
                chk($sformatf("r%0d_wait_stall", it), 32'(stall), 32'h1);
                tick();
                chk($sformatf("r%0d_bubble", it), 32'(wbv_o), 32'h0);
            end
            ack = (mode != MA_NONE);
            #1;
            chk($sformatf("r%0d_req", it), 32'(req), 32'(mode != MA_NONE));
            if (mode != MA_NONE) begin
                chk($sformatf("r%0d_addr", it), daddr, addr & 32'hFFFF_FFFC);
                chk($sformatf("r%0d_we", it), 32'(we), 32'(mode == MA_STORE));
                chk($sformatf("r%0d_be", it), 32'(be), (mode == MA_STORE) ? 32'(model_be(size, addr)) : 32'hF);
                chk($sformatf("r%0d_stall", it), 32'(stall), 32'h0);
            end
            if (mode == MA_STORE) chk($sformatf("r%0d_wdata", it), wdata, model_wdata(size, sdata));
            chk($sformatf("r%0d_wbda", it), wbda, exp_wb);
            tick();
            chk($sformatf("r%0d_wbd_o", it), wbd_o, exp_wb);
            chk($sformatf("r%0d_wbv_o", it), 32'(wbv_o), 32'(wbv));
            chk($sformatf("r%0d_pc_o", it), pc_o, pc);
            chk($sformatf("r%0d_ir_o", it), ir_o, ir);
            ack = 1'b0;
        end
        mode = MA_NONE;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
